// File: rtl/chunked_serial_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chunked_serial_adder: multi-cycle add/subtract, CHUNK bits per clock,      |
// | LSB chunk first, registered carry, start/busy/done handshake.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module chunked_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             overflow
);

  // WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH.
  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_chunk;
  int               base;

  always_comb begin
    base    = int'(idx_q) * CHUNK;
    a_chunk = a_q[base +: CHUNK];
    b_chunk = b_q[base +: CHUNK];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          // Subtraction is A + ~B + 1; the +1 rides in on the initial carry.
          b_d     = sub ? ~B : B;
          carry_d = sub | Cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[base +: CHUNK] = s_chunk;
        carry_d              = c_chunk;
        idx_d                = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = c_chunk;
          // Carry into the MSB recovered from the MSB's own sum bit.
          ovf_d   = s_chunk[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ c_chunk;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire
